// File: rtl/move_seq.sv
// Move sequencer: waits for the heading to settle, ramps forward speed up,
// counts centre-line crossings, ramps down on the final square, then pulses done.
//
// state   | meaning
// IDLE    | waiting for start
// ALIGN   | PID enabled at zero speed until heading error settles
// RAMP_UP | accelerating on each hdg_rdy, watching for target-1 lines
// RAMP_DN | decelerating on each hdg_rdy until frwrd reaches 0
// DONE    | one-cycle completion pulse
module move_seq #(
  parameter logic [9:0]  RAMP_INC = 10'd4,
  parameter logic [9:0]  MAX_SPD  = 10'h2A0,
  parameter logic [11:0] ERR_THR  = 12'd48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        squares,
  input  logic              hdg_rdy,
  input  logic signed [11:0] error,
  input  logic              cntrIR,
  output logic              moving,
  output logic [9:0]        frwrd,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ALIGN   = 3'd1;
  localparam logic [2:0] RAMP_UP = 3'd2;
  localparam logic [2:0] RAMP_DN = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [3:0]  line_cnt, line_cnt_nxt;
  logic [3:0]  target, target_nxt;
  logic [9:0]  frwrd_nxt;
  logic        cntrIR_ff;
  logic        line_edge;
  logic [11:0] err_mag;
  logic        settled;
  logic [10:0] spd_sum;
  logic [10:0] spd_dec;

  assign line_edge = cntrIR & ~cntrIR_ff;

  // -2048 negates to itself (0x800), which is never below the threshold
  assign err_mag = error[11] ? ($unsigned(~error) + 12'd1) : $unsigned(error);
  assign settled = (err_mag < ERR_THR);

  assign spd_sum = {1'b0, frwrd} + {1'b0, RAMP_INC};
  assign spd_dec = {1'b0, RAMP_INC} << 1;

  always_comb begin
    state_nxt    = state;
    frwrd_nxt    = frwrd;
    target_nxt   = target;
    line_cnt_nxt = line_cnt;
    if ((state != IDLE) && line_edge && (line_cnt != 4'hF))
      line_cnt_nxt = line_cnt + 4'd1;
    case (state)
      IDLE: begin
        frwrd_nxt = 10'd0;
        if (start) begin
          if (squares != 3'd0) begin
            line_cnt_nxt = 4'd0;
            target_nxt   = {squares, 1'b0};
            state_nxt    = ALIGN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ALIGN: begin
        frwrd_nxt = 10'd0;
        if (hdg_rdy && settled)
          state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        // the line check sees this cycle's edge and wins over any speed step
        if (line_cnt_nxt >= (target - 4'd1))
          state_nxt = RAMP_DN;
        else if (hdg_rdy)
          frwrd_nxt = (spd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : spd_sum[9:0];
      end
      RAMP_DN: begin
        if (frwrd == 10'd0)
          state_nxt = DONE;
        else if (hdg_rdy)
          frwrd_nxt = ({1'b0, frwrd} > spd_dec) ? (frwrd - spd_dec[9:0]) : 10'd0;
      end
      DONE: begin
        frwrd_nxt = 10'd0;
        state_nxt = IDLE;
      end
      default: begin
        frwrd_nxt = 10'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      line_cnt  <= 4'd0;
      target    <= 4'd0;
      cntrIR_ff <= 1'b0;
      frwrd     <= 10'd0;
      moving    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      line_cnt  <= line_cnt_nxt;
      target    <= target_nxt;
      cntrIR_ff <= cntrIR;
      frwrd     <= frwrd_nxt;
      moving    <= (state_nxt == ALIGN) || (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_move_seq.sv
// Directed bench for move_seq: expected speeds are queued as each hdg_rdy
// strobe is driven and popped/compared once the registered frwrd updates.
module tb_move_seq;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        squares = 3'd0;
  logic              hdg_rdy = 1'b0;
  logic signed [11:0] error = 12'sd0;
  logic              cntrIR = 1'b0;
  logic              moving;
  logic [9:0]        frwrd;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int exp_spd = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  move_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .squares (squares),
    .hdg_rdy (hdg_rdy),
    .error   (error),
    .cntrIR  (cntrIR),
    .moving  (moving),
    .frwrd   (frwrd),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic m, input logic b, input logic d);
    check({tag, "_moving"}, {31'd0, moving}, {31'd0, m});
    check({tag, "_busy"},   {31'd0, busy},   {31'd0, b});
    check({tag, "_done"},   {31'd0, done},   {31'd0, d});
  endtask

  // mode 0: speed unchanged, 1: ramp-up step, 2: ramp-down step
  task automatic strobe(input int mode);
    logic [9:0] e;
    if (mode == 1) exp_spd = (exp_spd + 4 > 'h2A0) ? 'h2A0 : exp_spd + 4;
    if (mode == 2) exp_spd = (exp_spd > 8) ? exp_spd - 8 : 0;
    exp_q.push_back(10'(exp_spd));
    hdg_rdy = 1'b1;
    tick();
    hdg_rdy = 1'b0;
    e = exp_q.pop_front();
    check("frwrd", {22'd0, frwrd}, {22'd0, e});
  endtask

  initial begin
    // reset held with start asserted
    start = 1'b1;
    squares = 3'd1;
    tick(3);
    check("rst_frwrd", {22'd0, frwrd}, 32'd0);
    outs("rst", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    tick(2);
    outs("idle", 1'b0, 1'b0, 1'b0);

    // one-square move
    exp_spd = 0;
    squares = 3'd1;
    error = 12'sd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    outs("accept", 1'b1, 1'b1, 1'b0);
    check("accept_frwrd", {22'd0, frwrd}, 32'd0);
    strobe(0);
    for (int i = 0; i < 5; i++) begin
      tick(3);
      strobe(1);
    end
    tick(3);
    cntrIR = 1'b1;
    tick();
    cntrIR = 1'b0;
    check("decel_hold", {22'd0, frwrd}, 32'd20);
    tick(2);
    strobe(2);
    tick(3);
    strobe(2);
    tick(3);
    strobe(2);
    outs("at_zero", 1'b1, 1'b1, 1'b0);
    tick();
    outs("done1", 1'b0, 1'b1, 1'b1);
    tick();
    outs("idle1", 1'b0, 1'b0, 1'b0);
    check("done_cnt1", done_cnt, 32'd1);

    // settle gating with large error, then abort by reset in RAMP_UP
    exp_spd = 0;
    squares = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    error = 12'sd100;
    for (int i = 0; i < 10; i++) begin
      strobe(0);
      tick();
    end
    check("align_hold", {31'd0, moving}, 32'd1);
    error = 12'sd20;
    strobe(0);
    tick(3);
    strobe(1);
    rst_n = 1'b0;
    #1;
    check("midrst_frwrd", {22'd0, frwrd}, 32'd0);
    outs("midrst", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_nodone", done_cnt, 32'd1);

    // negative boundary, -2048, then ignored start and coincident edge+strobe
    exp_spd = 0;
    squares = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    error = -12'sd48;
    for (int i = 0; i < 3; i++) begin
      strobe(0);
      tick();
    end
    error = -12'sd2048;
    strobe(0);
    error = 12'sd48;
    strobe(0);
    error = -12'sd47;
    strobe(0);
    tick();
    strobe(1);
    start = 1'b1;
    squares = 3'd5;
    tick();
    start = 1'b0;
    check("ign_start_frwrd", {22'd0, frwrd}, 32'd4);
    outs("ign_start", 1'b1, 1'b1, 1'b0);
    tick();
    cntrIR = 1'b1;
    strobe(0);
    cntrIR = 1'b0;
    tick();
    strobe(2);
    tick();
    outs("done2", 1'b0, 1'b1, 1'b1);
    check("done2_frwrd", {22'd0, frwrd}, 32'd0);
    tick();
    check("done_cnt2", done_cnt, 32'd2);

    // zero squares: done without motion; start during DONE ignored
    squares = 3'd0;
    start = 1'b1;
    tick();
    outs("sq0_done", 1'b0, 1'b1, 1'b1);
    squares = 3'd1;
    tick();
    outs("sq0_idle", 1'b0, 1'b0, 1'b0);
    squares = 3'd0;
    tick();
    start = 1'b0;
    outs("sq0_again", 1'b0, 1'b1, 1'b1);
    tick();
    check("done_cnt3", done_cnt, 32'd4);

    // saturation at MAX_SPD
    exp_spd = 0;
    error = 12'sd0;
    squares = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    strobe(0);
    for (int i = 0; i < 300; i++) begin
      tick();
      strobe(1);
    end
    check("sat_frwrd", {22'd0, frwrd}, 32'h2A0);
    outs("sat", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(2);
    check("final_done_cnt", done_cnt, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_seq.md
# move_seq

Move sequencer that drives the `moving` and `frwrd` inputs of the heading PID. It accepts a move command (a number of squares) and waits for the heading error to settle. It then ramps forward speed up, counts centre-line crossings, ramps speed down to zero on the final square, and pulses `done`. It sits between the command processor and the PID/motor-drive path.

## Interface
- `RAMP_INC`, default 10'd4: `frwrd` increment per `hdg_rdy` strobe during ramp-up. The ramp-down step is 2×`RAMP_INC`.
- `MAX_SPD`, default 10'h2A0: ceiling for `frwrd`.
- `ERR_THR`, default 12'd48: heading is settled when |`error`| < `ERR_THR`.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle move request. Sampled only in IDLE.
- `squares` input 3: squares to travel, 0..7. Sampled when `start` is accepted.
- `hdg_rdy` input 1: one-cycle strobe marking a new heading sample. All ramp steps and the settle check occur only on this strobe.
- `error` input 12 signed: heading error, the same value fed to the PID.
- `cntrIR` input 1: centre-line IR sensor, already synchronized. Each rising edge is one line; one square = 2 lines.
- `moving` output 1: PID enable; the integrator clears when low.
- `frwrd` output 10: unsigned forward speed to the PID.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a move completes.

## Operation
- All outputs are registered. Reset values: `moving`=0, `frwrd`=0, `busy`=0, `done`=0, state=IDLE, line counter=0, target=0, `cntrIR` history flop=0.
- Line edge: `cntrIR_ff` holds the previous `cntrIR`. `line_edge` = `cntrIR` & ~`cntrIR_ff`. In any non-IDLE state, each `line_edge` increments the 4-bit line counter, which saturates at 15.
- Target: captured at accept as {`squares`,1'b0}, i.e. 2×squares lines. Deceleration triggers when line counter ≥ target−1.
- IDLE:
  - `start` & `squares`≠0: clear line counter, latch target, go to ALIGN.
  - `start` & `squares`=0: go to DONE directly. No motion; `moving` stays 0.
  - `start` while not IDLE is ignored.
- ALIGN:
  - `moving`=1, `frwrd`=0.
  - On `hdg_rdy` with |`error`| < `ERR_THR`: go to RAMP_UP.
  - Magnitude uses 12-bit two's complement. -2048 counts as not settled.
- RAMP_UP:
  - On `hdg_rdy`: `frwrd` ← min(`frwrd`+`RAMP_INC`, `MAX_SPD`). Compute the sum in 11 bits so it cannot wrap.
  - When the line counter (including an edge arriving this cycle) reaches target−1: go to RAMP_DN. Any `frwrd` increment this cycle is suppressed.
- RAMP_DN:
  - On `hdg_rdy`: `frwrd` ← max(`frwrd`−2·`RAMP_INC`, 0). Compute as a compare, not a wrapping subtract.
  - When `frwrd` is 0 at the start of a cycle: go to DONE.
  - Line edges are still counted here; extra edges beyond target are harmless.
- DONE:
  - `done`=1, `moving`=0, `frwrd`=0, `busy`=1 for exactly one cycle, then IDLE.
- Simultaneous `hdg_rdy` and `line_edge`: both are processed in the same cycle. The edge is counted and the transition check uses the updated count.
- Reset asserted mid-move: immediate return to reset values. No `done` pulse.

## Timing
- `start` accepted at edge N: state=ALIGN, `busy`=1 and `moving`=1 visible after edge N.
- Each `frwrd` update is visible one cycle after the `hdg_rdy` cycle.
- `line_edge` counts one cycle after `cntrIR` rises (history flop).
- RAMP_DN → DONE: the cycle after `frwrd` registers 0. `done` is high for 1 cycle; `busy` drops on the following edge.
- `start` in DONE is ignored. `start` can be accepted in the first IDLE cycle after DONE.
- The downstream PID adds 2 cycles of latency to the speed outputs. No compensation is done here.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs 0 and state IDLE. Release, then pulse `start` → ALIGN next cycle.
- 1-square move, `error`=0, `hdg_rdy` every 4 cycles:
  - ALIGN exits on the first strobe.
  - `frwrd` steps 4,8,12… until one `cntrIR` pulse.
  - RAMP_DN then steps by 8 down to 0.
  - `done` pulses once; `moving` falls with `done`.
- Settle gating: `error`=+100 for 10 strobes, then 20 → ALIGN holds with `frwrd`=0, exits on the first strobe with `error`=20. Repeat with `error`=-48 → still held (boundary).
- Saturation: `squares`=7, no `cntrIR` for 300 strobes → `frwrd` ramps to 0x2A0 and holds; never exceeds or wraps.
- Ramp-down floor: `RAMP_INC`=4, ramp-down entered with `frwrd`=6 → next strobe gives 0, not wraparound; DONE follows.
- Edge cases:
  - `squares`=0 → `done` one cycle after accept, `moving` never 1.
  - `start` during RAMP_UP → ignored.
  - `rst_n` pulsed low in RAMP_UP → outputs 0 immediately, no `done`.
  - `cntrIR` edge coincident with `hdg_rdy` at target−1 → RAMP_DN with no increment that cycle.
